trace_core_driver: RTL
======================

# trace_core_driver

Parametrised trace-driven processor-core model that replays a loaded instruction trace as read/write requests into the L1 cache under test. It sits in the core slot of the cache testbench/SoC model, one instance per core. It replaces free-running fixed-rate stepping with a request/acknowledge handshake, programmable delays, explicit halt and loop modes. The trace RAM is loaded through a write port rather than a file.

## Interface
- ADDR_W, 16, request address width
- DATA_W, 8, data width
- DEPTH, 64, trace entries (power of two, ≥2)
- CNT_W, 16, width of retired/stall counters
- Instruction word IW = 2+ADDR_W+DATA_W: [IW-1:IW-2] op (00 read, 01 write, 10 delay, 11 halt), then address, then data in [DATA_W-1:0]

- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ld_we  in  1  trace RAM write strobe
- ld_addr  in  log2(DEPTH)  trace RAM write index
- ld_data  in  IW  trace word
- start  in  1  begin replay from entry 0
- loop_en  in  1  wrap to entry 0 after last entry instead of halting
- ack  in  1  cache completion of current request
- fetched_data  in  DATA_W  read data, valid with ack
- read  out  1  read request
- write  out  1  write request
- address  out  ADDR_W  request address
- write_data  out  DATA_W  write data; 0 when write=0
- rd_data  out  DATA_W  last captured read data
- rd_valid  out  1  one-cycle pulse when rd_data updates
- busy  out  1  state not IDLE/HALT
- done  out  1  state HALT
- retired  out  CNT_W  completed read/write count, saturating
- stalls  out  CNT_W  ISSUE cycles with ack=0, saturating

## Operation
- States: IDLE, FETCH, ISSUE, DELAY, HALT.
- IDLE: outputs idle. start → FETCH with pc=0; retired/stalls cleared.
- FETCH (1 cycle): decode mem[pc].
  - read/write → ISSUE; read/write/address/write_data registered from the word.
  - delay → DELAY with count = data field; count 0 advances immediately.
  - halt → HALT.
- ISSUE: request held stable until ack.
  - ack=0: stalls++.
  - ack=1: deassert request next cycle; retired++; advance.
  - On reads, rd_data ← fetched_data and rd_valid pulses.
- DELAY: decrement each cycle; at 0 advance.
- Advance: if pc=DEPTH-1, then loop_en=1 → pc=0, FETCH; else → HALT. Otherwise pc++, FETCH.
- HALT: done=1; start → FETCH with pc=0, counters cleared.
- read and write never both 1; both 0 outside ISSUE.
- ld_we takes effect only in IDLE/HALT; ignored while busy. Same-cycle ld_we and start: write lands first, start takes effect.
- Counters saturate at all-ones.
- ack outside ISSUE is ignored.

## Timing
- Reset: state IDLE, pc 0, all outputs 0 (read, write, address, write_data, rd_data, rd_valid, busy, done, retired, stalls). Trace RAM contents are not reset.
- start sampled at edge N → FETCH in cycle N+1 → request visible from cycle N+2.
- Minimum request cadence: 2 cycles (FETCH + ISSUE with immediate ack).
- Request deasserts in the cycle after the ack edge; the next request appears one cycle later.
- Delay word with D: D+1 cycles from FETCH to next FETCH.
- rd_valid is high in the cycle after the ack edge, concurrent with rd_data update.
- Reset mid-ISSUE drops the request immediately (asynchronous).

## Configuration
- TRACE_CHECK_EN defined:
  - read words carry the expected data in the data field; on read ack, fetched_data is compared against it.
  - Adds outputs mismatch (sticky, cleared by start/rst) and mismatch_cnt (CNT_W, saturating).
  - Mismatch does not stop replay.
- TRACE_CHECK_EN undefined: data field of read words ignored; no compare logic; mismatch ports absent.

## Test plan
- Load [W 0x0010←0xA5, R 0x0010, HALT]; ack 1 cycle after each request → write at cycle N+2 with address 0x0010, data 0xA5; read issued; rd_data=0xA5 with rd_valid pulse; done=1; retired=2.
- Read with ack held low 5 cycles → address stable throughout, stalls=5, retired=1.
- Delay word D=3 between two writes → exactly 4 cycles between the FETCHes.
- DEPTH entries, no halt, loop_en=1 → pc wraps to 0 and entry 0 is reissued. Same trace with loop_en=0 → HALT after entry DEPTH-1.
- rst asserted mid-ISSUE → read/write drop asynchronously, outputs 0. After restart, trace replays from 0 with the RAM contents intact.
- TRACE_CHECK_EN: read expects 0x3C, cache returns 0x3D → mismatch=1, mismatch_cnt=1, replay continues to HALT.

Source files
------------

// File: rtl/trace_core_driver.sv
// Trace-driven core model: replays a loaded trace of read/write/delay/halt words as handshaked cache requests.
// Optional feature macro TRACE_CHECK_EN: compare read data against the trace and report mismatches.
module trace_core_driver #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16,
    localparam int IW    = 2 + ADDR_W + DATA_W,
    localparam int PC_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_we,
    input  logic [PC_W-1:0]   ld_addr,
    input  logic [IW-1:0]     ld_data,
    input  logic              start,
    input  logic              loop_en,
    input  logic              ack,
    input  logic [DATA_W-1:0] fetched_data,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  retired,
`ifdef TRACE_CHECK_EN
    output logic [CNT_W-1:0]  stalls,
    output logic              mismatch,
    output logic [CNT_W-1:0]  mismatch_cnt
`else
    output logic [CNT_W-1:0]  stalls
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DELAY, HALT} state_e;
    typedef enum logic [1:0] {OP_READ = 2'b00, OP_WRITE = 2'b01, OP_DELAY = 2'b10, OP_HALT = 2'b11} op_e;

    logic [IW-1:0]     mem [DEPTH];
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              read_q, read_d, write_q, write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [DATA_W-1:0] dly_q, dly_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]  retired_q, retired_d, stalls_q, stalls_d;
`ifdef TRACE_CHECK_EN
    logic [DATA_W-1:0] expect_q, expect_d;
    logic              mismatch_q, mismatch_d;
    logic [CNT_W-1:0]  mismatch_cnt_q, mismatch_cnt_d;
`endif
    logic [IW-1:0]     word;
    logic              idle_like;
    op_e               op;
    logic              advance;

    assign idle_like = (state_q == IDLE) || (state_q == HALT);
    assign word      = mem[pc_q];

    // Loading is only honoured while the replay is stopped.
    always_ff @(posedge clk) begin
        if (ld_we && idle_like) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        dly_d        = dly_q;
        retired_d    = retired_q;
        stalls_d     = stalls_q;
`ifdef TRACE_CHECK_EN
        expect_d       = expect_q;
        mismatch_d     = mismatch_q;
        mismatch_cnt_d = mismatch_cnt_q;
`endif
        advance      = 1'b0;
        op           = op_e'(word[IW-1 -: 2]);

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d   = FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                    stalls_d  = '0;
`ifdef TRACE_CHECK_EN
                    mismatch_d     = 1'b0;
                    mismatch_cnt_d = '0;
`endif
                end
            end
            FETCH: begin
                case (op)
                    OP_READ: begin
                        state_d      = ISSUE;
                        read_d       = 1'b1;
                        address_d    = word[DATA_W +: ADDR_W];
                        write_data_d = '0;
`ifdef TRACE_CHECK_EN
                        expect_d     = word[DATA_W-1:0];
`endif
                    end
                    OP_WRITE: begin
                        state_d      = ISSUE;
                        write_d      = 1'b1;
                        address_d    = word[DATA_W +: ADDR_W];
                        write_data_d = word[DATA_W-1:0];
                    end
                    OP_DELAY: begin
                        if (word[DATA_W-1:0] == '0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = DELAY;
                            dly_d   = word[DATA_W-1:0];
                        end
                    end
                    OP_HALT: state_d = HALT;
                endcase
            end
            ISSUE: begin
                if (ack) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    address_d    = '0;
                    write_data_d = '0;
                    advance      = 1'b1;
                    if (retired_q != '1) retired_d = retired_q + CNT_W'(1);
                    if (read_q) begin
                        rd_data_d  = fetched_data;
                        rd_valid_d = 1'b1;
`ifdef TRACE_CHECK_EN
                        if (fetched_data != expect_q) begin
                            mismatch_d = 1'b1;
                            if (mismatch_cnt_q != '1) mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
                        end
`endif
                    end
                end else if (stalls_q != '1) begin
                    stalls_d = stalls_q + CNT_W'(1);
                end
            end
            // Loaded with D, leaves on the cycle showing 1: D cycles here, D+1 fetch to fetch.
            DELAY: begin
                if (dly_q <= DATA_W'(1)) advance = 1'b1;
                else dly_d = dly_q - DATA_W'(1);
            end
            default: state_d = IDLE;
        endcase

        if (advance) begin
            if (pc_q == PC_W'(DEPTH - 1)) begin
                if (loop_en) begin
                    pc_d    = '0;
                    state_d = FETCH;
                end else begin
                    state_d = HALT;
                end
            end else begin
                pc_d    = pc_q + PC_W'(1);
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            dly_q        <= '0;
            retired_q    <= '0;
            stalls_q     <= '0;
`ifdef TRACE_CHECK_EN
            expect_q       <= '0;
            mismatch_q     <= 1'b0;
            mismatch_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            dly_q        <= dly_d;
            retired_q    <= retired_d;
            stalls_q     <= stalls_d;
`ifdef TRACE_CHECK_EN
            expect_q       <= expect_d;
            mismatch_q     <= mismatch_d;
            mismatch_cnt_q <= mismatch_cnt_d;
`endif
        end
    end

    assign read       = read_q;
    assign write      = write_q;
    assign address    = address_q;
    assign write_data = write_data_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign busy       = !idle_like;
    assign done       = (state_q == HALT);
    assign retired    = retired_q;
    assign stalls     = stalls_q;
`ifdef TRACE_CHECK_EN
    assign mismatch     = mismatch_q;
    assign mismatch_cnt = mismatch_cnt_q;
`endif

endmodule
